// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: states, opcodes,
// datapath mux selects, ALUOp and ALUControl values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_JAL      = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps ALUOp plus instruction fields to ALUControl.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // Only register-register sub sets IR[30]; addi must never become sub.
          3'b000:  alu_control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: steps fetch/decode/execute/
// memory/writeback and drives the shared datapath muxes and memory port.
//
// state      | meaning
// S_IDLE     | post-reset hold, all outputs 0
// S_FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// S_DECODE   | branch target (OldPC+imm) into ALUOut
// S_MEMADR   | rs1+imm address into ALUOut
// S_MEMREAD  | load request at ALUOut
// S_MEMWB    | write load data to rd
// S_MEMWRITE | store request at ALUOut
// S_EXECR    | register-register ALU op
// S_EXECI    | register-immediate ALU op
// S_ALUWB    | write ALUOut to rd
// S_BRANCH   | compare rs1/rs2, PC <= ALUOut if taken
// S_JALR     | rs1+imm target into ALUOut
// S_JAL      | PC <= ALUOut, OldPC+4 computed for rd
// S_UPPER    | lui/auipc result
// S_TRAP     | unsupported opcode, absorbing until reset
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LessThanS,
  input  logic       LessThanU,
  input  logic       mem_ready,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] LoadType,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state;
  logic [3:0] hold_cnt;
  logic [1:0] alu_op;
  logic       take_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hold_cnt <= 4'(RESET_PC_HOLD);
    end else begin
      case (state)
        S_IDLE: begin
          if (hold_cnt <= 4'd1) state <= S_FETCH;
          else hold_cnt <= hold_cnt - 4'd1;
        end
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_R:              state <= S_EXECR;
            OP_I:              state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI, OP_AUIPC:  state <= S_UPPER;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JALR:     state <= S_JAL;
        S_JAL:      state <= S_ALUWB;
        S_UPPER:    state <= S_ALUWB;
        default:    state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    take_branch = 1'b0;
    case (funct3)
      3'b000:  take_branch = Zero;
      3'b001:  take_branch = !Zero;
      3'b100:  take_branch = LessThanS;
      3'b101:  take_branch = !LessThanS;
      3'b110:  take_branch = LessThanU;
      3'b111:  take_branch = !LessThanU;
      default: take_branch = 1'b0;
    endcase
  end

  // Outputs decode straight from state so an async reset drops MemReq at once.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    LoadType  = 3'b000;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        LoadType  = funct3;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        PCWrite = take_branch;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
      end
      S_UPPER: begin
        ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .opb5        (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected output sequences built from
// instruction semantics, checked every cycle against the controller.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, LessThanS, LessThanU;
  logic       mem_ready;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] LoadType;
  logic       illegal;
  logic [3:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [23:0] v;
    logic        rdy;
    string       tag;
  } step_t;
  step_t q[$];

  logic [6:0] op_tab [9];

  multicycle_controller #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LessThanS(LessThanS), .LessThanU(LessThanU),
    .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .LoadType(LoadType),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  wire [23:0] act = {state_o, MemReq, MemWrite, AdrSrc, IRWrite, PCWrite,
                     RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                     LoadType, illegal};

  function automatic logic [23:0] mk(input state_t st, input logic mreq,
      input logic mw, input logic adr, input logic irw, input logic pcw,
      input logic rw, input logic [1:0] rs, input logic [1:0] sa,
      input logic [1:0] sb, input logic [3:0] alu, input logic [2:0] lt,
      input logic ill);
    return {4'(st), mreq, mw, adr, irw, pcw, rw, rs, sa, sb, alu, lt, ill};
  endfunction

  // ALU function implied by the mnemonic of an R-type or I-type instruction.
  function automatic logic [3:0] mnemonic_alu(input logic is_r,
      input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return f7 ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
      input logic lts, input logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lts;
      3'd5: return !lts;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [23:0] v, input logic rdy, input string tag);
    step_t s;
    s.v = v; s.rdy = rdy; s.tag = tag;
    q.push_back(s);
  endtask

  task automatic check(input logic [23:0] exp, input string tag);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic push_idle();
    push(mk(S_IDLE, 0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 0), rnd(), "idle");
  endtask

  task automatic push_aluwb();
    push(mk(S_ALUWB, 0,0,0,0,0,1, RES_ALUOUT, 2'd0, 2'd0, ALU_ADD, 3'd0, 0), rnd(), "aluwb");
  endtask

  // Sets instruction fields/flags and queues the expected per-cycle outputs.
  task automatic build_instr(input logic [6:0] o, input logic [2:0] f3,
      input logic f7, input logic z, input logic lts, input logic ltu,
      input int wf, input int wm);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; LessThanS = lts; LessThanU = ltu;
    for (int i = 0; i < wf; i++)
      push(mk(S_FETCH, 1,0,0,0,0,0, RES_ALURES, SRCA_PC, SRCB_FOUR, ALU_ADD, 3'd0, 0), 1'b0, "fetch_wait");
    push(mk(S_FETCH, 1,0,0,1,1,0, RES_ALURES, SRCA_PC, SRCB_FOUR, ALU_ADD, 3'd0, 0), 1'b1, "fetch_done");
    push(mk(S_DECODE, 0,0,0,0,0,0, RES_ALUOUT, SRCA_OLDPC, SRCB_IMM, ALU_ADD, 3'd0, 0), rnd(), "decode");
    case (o)
      OP_LOAD, OP_STORE: begin
        push(mk(S_MEMADR, 0,0,0,0,0,0, RES_ALUOUT, SRCA_RS1, SRCB_IMM, ALU_ADD, 3'd0, 0), rnd(), "memadr");
        if (o == OP_LOAD) begin
          for (int i = 0; i <= wm; i++)
            push(mk(S_MEMREAD, 1,0,1,0,0,0, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 0), (i == wm), "memread");
          push(mk(S_MEMWB, 0,0,0,0,0,1, RES_RDATA, 2'd0, 2'd0, ALU_ADD, f3, 0), rnd(), "memwb");
        end else begin
          for (int i = 0; i <= wm; i++)
            push(mk(S_MEMWRITE, 1,1,1,0,0,0, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 0), (i == wm), "memwrite");
        end
      end
      OP_R: begin
        push(mk(S_EXECR, 0,0,0,0,0,0, RES_ALUOUT, SRCA_RS1, SRCB_RS2, mnemonic_alu(1'b1, f3, f7), 3'd0, 0), rnd(), "execr");
        push_aluwb();
      end
      OP_I: begin
        push(mk(S_EXECI, 0,0,0,0,0,0, RES_ALUOUT, SRCA_RS1, SRCB_IMM, mnemonic_alu(1'b0, f3, f7), 3'd0, 0), rnd(), "execi");
        push_aluwb();
      end
      OP_BRANCH:
        push(mk(S_BRANCH, 0,0,0,0, branch_taken(f3, z, lts, ltu), 0, RES_ALUOUT, SRCA_RS1, SRCB_RS2, ALU_SUB, 3'd0, 0), rnd(), "branch");
      OP_JAL, OP_JALR: begin
        if (o == OP_JALR)
          push(mk(S_JALR, 0,0,0,0,0,0, RES_ALUOUT, SRCA_RS1, SRCB_IMM, ALU_ADD, 3'd0, 0), rnd(), "jalr");
        push(mk(S_JAL, 0,0,0,0,1,0, RES_ALUOUT, SRCA_OLDPC, SRCB_FOUR, ALU_ADD, 3'd0, 0), rnd(), "jal");
        push_aluwb();
      end
      OP_LUI, OP_AUIPC: begin
        push(mk(S_UPPER, 0,0,0,0,0,0, RES_ALUOUT, (o == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC, SRCB_IMM, ALU_ADD, 3'd0, 0), rnd(), "upper");
        push_aluwb();
      end
      default:
        for (int i = 0; i < 10; i++)
          push(mk(S_TRAP, 0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, ALU_ADD, 3'd0, 1), rnd(), "trap");
    endcase
  endtask

  // Entered and left at posedge+1: drive mem_ready, check at the falling edge.
  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      check(q[i].v, q[i].tag);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_all();
    run_steps(q.size());
    q.delete();
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_idle();
    run_all();
  endtask

  initial begin
    op_tab = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; LessThanS = 1'b0; LessThanU = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check(24'd0, "in_reset");
    release_reset();

    // add x3,x1,x2
    build_instr(OP_R, 3'd0, 1'b0, 0, 0, 0, 0, 0); run_all();
    // lw with three wait cycles
    build_instr(OP_LOAD, 3'b010, 1'b0, 0, 0, 0, 0, 3); run_all();
    // beq Z=1, bne Z=1, bltu LTU=1, funct3=010
    build_instr(OP_BRANCH, 3'b000, 1'b0, 1, 0, 0, 0, 0); run_all();
    build_instr(OP_BRANCH, 3'b001, 1'b0, 1, 0, 0, 0, 0); run_all();
    build_instr(OP_BRANCH, 3'b110, 1'b0, 0, 0, 1, 0, 0); run_all();
    build_instr(OP_BRANCH, 3'b010, 1'b0, 1, 1, 1, 0, 0); run_all();
    build_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 0, 1, 0); run_all();
    build_instr(OP_R, 3'b000, 1'b1, 0, 0, 0, 0, 0); run_all();
    build_instr(OP_I, 3'b000, 1'b1, 0, 0, 0, 0, 0); run_all();
    build_instr(OP_I, 3'b101, 1'b1, 0, 0, 0, 2, 0); run_all();

    for (int n = 0; n < 150; n++) begin
      build_instr(op_tab[$urandom_range(0, 8)], 3'($urandom), rnd(), rnd(), rnd(), rnd(),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      run_all();
    end

    // Unsupported opcode traps; reset clears illegal.
    build_instr(7'b0000000, 3'd0, 1'b0, 0, 0, 0, 0, 0); run_all();
    rst_n = 1'b0; #1;
    check(24'd0, "trap_reset");
    release_reset();

    // Reset two cycles into a store's wait: request must drop asynchronously.
    build_instr(OP_STORE, 3'b010, 1'b0, 0, 0, 0, 0, 5);
    run_steps(5);
    mem_ready = 1'b0; #1;
    check(q[5].v, "store_wait");
    rst_n = 1'b0; #1;
    check(24'd0, "store_abort");
    q.delete();
    release_reset();
    build_instr(OP_R, 3'd7, 1'b0, 0, 0, 0, 1, 0); run_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
